// File: rtl/prbs5_checker.sv
// Self-synchronising checker for the x^5+x^3+1 Galois LFSR state stream.
// It seeds from the received words, confirms a run of correct predictions, then flywheels and counts mismatches.
module prbs5_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [4:0]       in_data,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic             lock_lost,
  output logic [ERR_W-1:0] err_count
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_CNT - 1);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_CNT - 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t          state;
  logic [4:0]      exp_q;
  logic            have_seed;
  logic [MW-1:0]   match_run;
  logic [LW-1:0]   miss_run;

  function automatic logic [4:0] lfsr_next(input logic [4:0] q);
    return {q[0], q[4], q[3] ^ q[0], q[2], q[1]};
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    return (&c) ? c : c + ERR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SEARCH;
      exp_q     <= '0;
      have_seed <= 1'b0;
      match_run <= '0;
      miss_run  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      lock_lost <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= 1'b0;
      lock_lost <= 1'b0;
      if (clear_cnt)
        err_count <= '0;
      if (in_valid) begin
        case (state)
          SEARCH: begin
            // The all-zero word is the LFSR lockup state and can never seed a prediction.
            if (in_data == 5'd0) begin
              have_seed <= 1'b0;
              match_run <= '0;
            end else begin
              exp_q     <= lfsr_next(in_data);
              have_seed <= 1'b1;
              if (have_seed && in_data == exp_q) begin
                match_run <= match_run + MW'(1);
                if (match_run == LOCK_LAST) begin
                  state    <= LOCKED;
                  locked   <= 1'b1;
                  miss_run <= '0;
                end
              end else begin
                match_run <= '0;
              end
            end
          end
          LOCKED: begin
            // Flywheel on the local prediction so a corrupted word never re-seeds.
            exp_q <= lfsr_next(exp_q);
            if (in_data == exp_q) begin
              miss_run <= '0;
            end else begin
              err_pulse <= 1'b1;
              if (!clear_cnt)
                err_count <= sat_inc(err_count);
              if (miss_run == LOSS_LAST) begin
                state     <= SEARCH;
                locked    <= 1'b0;
                lock_lost <= 1'b1;
                have_seed <= 1'b0;
                match_run <= '0;
                miss_run  <= '0;
              end else begin
                miss_run <= miss_run + LW'(1);
              end
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prbs5_checker.sv
// Directed bench for prbs5_checker: a vector table for lock/error/loss/gap behaviour,
// followed by a hand-written saturation, clear and reset sequence on a narrow-counter instance.
module tb_prbs5_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [4:0]  in_data = 5'd0;
  logic        clear_cnt = 1'b0;

  logic        locked, err_pulse, lock_lost;
  logic [15:0] err_count;
  logic        locked4, err_pulse4, lock_lost4;
  logic [3:0]  err_count4;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  prbs5_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .clear_cnt(clear_cnt), .locked(locked), .err_pulse(err_pulse),
    .lock_lost(lock_lost), .err_count(err_count)
  );

  prbs5_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .clear_cnt(clear_cnt), .locked(locked4), .err_pulse(err_pulse4),
    .lock_lost(lock_lost4), .err_count(err_count4)
  );

  typedef struct {
    logic        r;
    logic        vl;
    logic [4:0]  d;
    logic        c;
    logic        lk;
    logic        ep;
    logic        ll;
    logic [15:0] cnt;
  } vec_t;

  vec_t       vecs[$];
  logic [4:0] g;

  function automatic logic [4:0] gen_next(input logic [4:0] q);
    return {q[0], q[4], q[3] ^ q[0], q[2], q[1]};
  endfunction

  function automatic void v(logic r, logic vl, logic [4:0] d, logic c,
                            logic lk, logic ep, logic ll, logic [15:0] cnt);
    vec_t e;
    e.r = r; e.vl = vl; e.d = d; e.c = c;
    e.lk = lk; e.ep = ep; e.ll = ll; e.cnt = cnt;
    vecs.push_back(e);
  endfunction

  // Send the next generator word (optionally with bit 0 flipped) and advance the generator.
  function automatic void send(logic corrupt, logic clr,
                               logic lk, logic ep, logic ll, logic [15:0] cnt);
    v(1'b0, 1'b1, g ^ {4'd0, corrupt}, clr, lk, ep, ll, cnt);
    g = gen_next(g);
  endfunction

  function automatic void gap(logic lk, logic [15:0] cnt);
    v(1'b0, 1'b0, 5'h13, 1'b0, lk, 1'b0, 1'b0, cnt);
  endfunction

  task automatic step(input logic r, input logic vl, input logic [4:0] d, input logic c);
    reset = r; in_valid = vl; in_data = d; clear_cnt = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check4(input string name, input logic lk, input logic ep,
                        input logic ll, input logic [3:0] cnt);
    n_vec++;
    if ({locked4, err_pulse4, lock_lost4, err_count4} !== {lk, ep, ll, cnt}) begin
      n_bad++;
      $display("FAIL %s: got locked=%0b err_pulse=%0b lock_lost=%0b err_count=%0d, want %0b %0b %0b %0d",
               name, locked4, err_pulse4, lock_lost4, err_count4, lk, ep, ll, cnt);
    end
  endtask

  task automatic check16(input string name, input logic lk, input logic [15:0] cnt);
    n_vec++;
    if ({locked, err_count} !== {lk, cnt}) begin
      n_bad++;
      $display("FAIL %s: got locked=%0b err_count=%0d, want %0b %0d",
               name, locked, err_count, lk, cnt);
    end
  endtask

  initial begin
    // Reset state
    v(1, 0, 5'd0, 0, 0, 0, 0, 0);
    v(1, 0, 5'd0, 0, 0, 0, 0, 0);
    // Lockup word stream never locks; zero mid-seed restarts the run
    for (int i = 0; i < 3; i++) v(0, 1, 5'd0, 0, 0, 0, 0, 0);
    g = 5'h01;
    for (int i = 0; i < 3; i++) send(0, 0, 0, 0, 0, 0);
    v(0, 1, 5'd0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) send(0, 0, 0, 0, 0, 0);
    send(0, 0, 1, 0, 0, 0);
    v(1, 1, g, 0, 0, 0, 0, 0);
    // Seed 0x01 then 0x14,0x0A,0x05,0x16
    g = 5'h01;
    for (int i = 0; i < 4; i++) send(0, 0, 0, 0, 0, 0);
    send(0, 0, 1, 0, 0, 0);
    // Single corrupt word while locked
    send(0, 0, 1, 0, 0, 0);
    send(1, 0, 1, 1, 0, 1);
    for (int i = 0; i < 3; i++) send(0, 0, 1, 0, 0, 1);
    // Three consecutive errors drop lock, then relock after seed + 4 matches
    send(1, 0, 1, 1, 0, 2);
    send(1, 0, 1, 1, 0, 3);
    send(1, 0, 0, 1, 1, 4);
    for (int i = 0; i < 4; i++) send(0, 0, 0, 0, 0, 4);
    send(0, 0, 1, 0, 0, 4);
    // Two misses then a match keeps lock
    send(1, 0, 1, 1, 0, 5);
    send(1, 0, 1, 1, 0, 6);
    send(0, 0, 1, 0, 0, 6);
    send(1, 0, 1, 1, 0, 7);
    // Idle clear, then clear coincident with an error
    v(0, 0, 5'h13, 1, 1, 0, 0, 0);
    send(1, 1, 1, 1, 0, 0);
    send(0, 0, 1, 0, 0, 0);
    // Same lock stream with valid gaps
    v(1, 0, 5'd0, 0, 0, 0, 0, 0);
    g = 5'h01;
    send(0, 0, 0, 0, 0, 0);
    gap(0, 0); gap(0, 0);
    send(0, 0, 0, 0, 0, 0);
    gap(0, 0);
    send(0, 0, 0, 0, 0, 0);
    gap(0, 0); gap(0, 0); gap(0, 0);
    send(0, 0, 0, 0, 0, 0);
    gap(0, 0);
    send(0, 0, 1, 0, 0, 0);
    send(1, 0, 1, 1, 0, 1);
    gap(1, 1);
    send(0, 0, 1, 0, 0, 1);
    send(1, 0, 1, 1, 0, 2);
    send(1, 0, 1, 1, 0, 3);
    send(1, 0, 0, 1, 1, 4);
    gap(0, 4);

    @(negedge clk);
    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].vl, vecs[i].d, vecs[i].c);
      n_vec++;
      if ({locked, err_pulse, lock_lost, err_count} !==
          {vecs[i].lk, vecs[i].ep, vecs[i].ll, vecs[i].cnt}) begin
        n_bad++;
        $display("FAIL vec%0d: got locked=%0b err_pulse=%0b lock_lost=%0b err_count=%0d, want %0b %0b %0b %0d",
                 i, locked, err_pulse, lock_lost, err_count,
                 vecs[i].lk, vecs[i].ep, vecs[i].ll, vecs[i].cnt);
      end
    end

    // Narrow counter saturation, clear priority and reset while locked
    step(1, 0, 5'd0, 0);
    check4("sat_reset", 0, 0, 0, 4'd0);
    g = 5'h01;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, g, 0);
      g = gen_next(g);
    end
    check4("sat_lock", 1, 0, 0, 4'd0);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, g ^ 5'h01, 0);
      g = gen_next(g);
      if (i == 14) check4("sat_at15", 1, 1, 0, 4'd15);
      if (i == 15) check4("sat_hold", 1, 1, 0, 4'd15);
      step(0, 1, g, 0);
      g = gen_next(g);
    end
    check4("sat_end", 1, 0, 0, 4'd15);
    check16("wide_count20", 1, 16'd20);
    step(0, 1, g ^ 5'h01, 1);
    g = gen_next(g);
    check4("clear_with_err", 1, 1, 0, 4'd0);
    step(1, 1, g, 0);
    check4("reset_locked", 0, 0, 0, 4'd0);
    check16("reset_locked16", 0, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
